// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection default and the
// command-master state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RSP,
        ST_FLUSH
    } state_e;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: one register command in, one AXI-Lite transaction out,
// one response back. Single outstanding transaction with a watchdog.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_LITE_DATA_WIDTH = 32,
    parameter int C_M_AXI_LITE_ADDR_WIDTH = 6,
    parameter int TIMEOUT_CYCLES          = 1024
) (
    input  logic                                   M_AXI_LITE_ACLK,
    input  logic                                   M_AXI_LITE_ARESETN,
    input  logic                                   CMD_VALID,
    output logic                                   CMD_READY,
    input  logic                                   CMD_WRITE,
    input  logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]     CMD_ADDR,
    input  logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     CMD_DATA,
    input  logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0]   CMD_STRB,
    output logic                                   RSP_VALID,
    input  logic                                   RSP_READY,
    output logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     RSP_DATA,
    output logic [1:0]                             RSP_RESP,
    output logic                                   RSP_TIMEOUT,
    output logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]     M_AXI_LITE_AWADDR,
    output logic [2:0]                             M_AXI_LITE_AWPROT,
    output logic                                   M_AXI_LITE_AWVALID,
    input  logic                                   M_AXI_LITE_AWREADY,
    output logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     M_AXI_LITE_WDATA,
    output logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0]   M_AXI_LITE_WSTRB,
    output logic                                   M_AXI_LITE_WVALID,
    input  logic                                   M_AXI_LITE_WREADY,
    input  logic [1:0]                             M_AXI_LITE_BRESP,
    input  logic                                   M_AXI_LITE_BVALID,
    output logic                                   M_AXI_LITE_BREADY,
    output logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]     M_AXI_LITE_ARADDR,
    output logic [2:0]                             M_AXI_LITE_ARPROT,
    output logic                                   M_AXI_LITE_ARVALID,
    input  logic                                   M_AXI_LITE_ARREADY,
    input  logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     M_AXI_LITE_RDATA,
    input  logic [1:0]                             M_AXI_LITE_RRESP,
    input  logic                                   M_AXI_LITE_RVALID,
    output logic                                   M_AXI_LITE_RREADY
);

    localparam int DW = C_M_AXI_LITE_DATA_WIDTH;
    localparam int AW = C_M_AXI_LITE_ADDR_WIDTH;
    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_e          state_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic [SW-1:0]   strb_q;
    logic            write_q;
    logic [CW-1:0]   cnt_q;
    logic            cmd_ready_q, rsp_valid_q, rsp_timeout_q;
    logic [DW-1:0]   rsp_data_q;
    logic [1:0]      rsp_resp_q;
    logic            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic            aw_done_q, w_done_q, b_done_q, ar_done_q, r_done_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic busy, hit, real_done, to_fire, all_done;

    assign aw_hs = awvalid_q & M_AXI_LITE_AWREADY;
    assign w_hs  = wvalid_q  & M_AXI_LITE_WREADY;
    assign b_hs  = bready_q  & M_AXI_LITE_BVALID;
    assign ar_hs = arvalid_q & M_AXI_LITE_ARREADY;
    assign r_hs  = rready_q  & M_AXI_LITE_RVALID;

    assign busy = (state_q == ST_WR_ADDR_DATA) || (state_q == ST_WR_RESP) ||
                  (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);
    assign hit  = (TIMEOUT_CYCLES != 0) && busy && (cnt_q == TO_LAST);
    // A B/R beat landing on the expiry cycle is a real answer and beats the timeout.
    assign real_done = ((state_q == ST_WR_RESP) && b_hs) || ((state_q == ST_RD_DATA) && r_hs);
    assign to_fire   = hit && !real_done;
    assign all_done  = (aw_done_q | aw_hs) & (w_done_q | w_hs) & (b_done_q | b_hs) &
                       (ar_done_q | ar_hs) & (r_done_q | r_hs);

    always_ff @(posedge M_AXI_LITE_ACLK or negedge M_AXI_LITE_ARESETN) begin
        if (!M_AXI_LITE_ARESETN) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            strb_q        <= '0;
            write_q       <= 1'b0;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= '0;
            rsp_resp_q    <= RESP_OKAY;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b1;
            w_done_q      <= 1'b1;
            b_done_q      <= 1'b1;
            ar_done_q     <= 1'b1;
            r_done_q      <= 1'b1;
        end else begin
            // Channel bookkeeping runs in every state so FLUSH sees late handshakes.
            if (aw_hs) begin awvalid_q <= 1'b0; aw_done_q <= 1'b1; end
            if (w_hs)  begin wvalid_q  <= 1'b0; w_done_q  <= 1'b1; end
            if (ar_hs) begin arvalid_q <= 1'b0; ar_done_q <= 1'b1; end
            if (b_hs)  b_done_q <= 1'b1;
            if (r_hs)  r_done_q <= 1'b1;
            if (busy && cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);

            if (to_fire) begin
                bready_q      <= 1'b0;
                rready_q      <= 1'b0;
                rsp_valid_q   <= 1'b1;
                rsp_timeout_q <= 1'b1;
                rsp_resp_q    <= RESP_DECERR;
                rsp_data_q    <= '0;
                state_q       <= ST_RSP;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cmd_ready_q && CMD_VALID) begin
                            cmd_ready_q <= 1'b0;
                            addr_q      <= CMD_ADDR;
                            data_q      <= CMD_DATA;
                            strb_q      <= CMD_STRB;
                            write_q     <= CMD_WRITE;
                            cnt_q       <= '0;
                            aw_done_q   <= !CMD_WRITE;
                            w_done_q    <= !CMD_WRITE;
                            b_done_q    <= !CMD_WRITE;
                            ar_done_q   <= CMD_WRITE;
                            r_done_q    <= CMD_WRITE;
                            if (CMD_WRITE) begin
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                state_q   <= ST_WR_ADDR_DATA;
                            end else begin
                                arvalid_q <= 1'b1;
                                state_q   <= ST_RD_ADDR;
                            end
                        end else begin
                            cmd_ready_q <= 1'b1;
                        end
                    end
                    ST_WR_ADDR_DATA: begin
                        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                            bready_q <= 1'b1;
                            state_q  <= ST_WR_RESP;
                        end
                    end
                    ST_WR_RESP: begin
                        if (b_hs) begin
                            bready_q      <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            rsp_timeout_q <= 1'b0;
                            rsp_resp_q    <= M_AXI_LITE_BRESP;
                            rsp_data_q    <= '0;
                            state_q       <= ST_RSP;
                        end
                    end
                    ST_RD_ADDR: begin
                        if (ar_hs) begin
                            rready_q <= 1'b1;
                            state_q  <= ST_RD_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (r_hs) begin
                            rready_q      <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            rsp_timeout_q <= 1'b0;
                            rsp_resp_q    <= M_AXI_LITE_RRESP;
                            rsp_data_q    <= M_AXI_LITE_RDATA;
                            state_q       <= ST_RSP;
                        end
                    end
                    ST_RSP: begin
                        if (RSP_READY) begin
                            rsp_valid_q   <= 1'b0;
                            rsp_timeout_q <= 1'b0;
                            rsp_resp_q    <= RESP_OKAY;
                            rsp_data_q    <= '0;
                            if (rsp_timeout_q) begin
                                bready_q <= write_q;
                                rready_q <= !write_q;
                                state_q  <= ST_FLUSH;
                            end else begin
                                cmd_ready_q <= 1'b1;
                                state_q     <= ST_IDLE;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        if (all_done) begin
                            bready_q    <= 1'b0;
                            rready_q    <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign CMD_READY          = cmd_ready_q;
    assign RSP_VALID          = rsp_valid_q;
    assign RSP_DATA           = rsp_data_q;
    assign RSP_RESP           = rsp_resp_q;
    assign RSP_TIMEOUT        = rsp_timeout_q;
    assign M_AXI_LITE_AWADDR  = addr_q;
    assign M_AXI_LITE_AWPROT  = PROT_DEFAULT;
    assign M_AXI_LITE_AWVALID = awvalid_q;
    assign M_AXI_LITE_WDATA   = data_q;
    assign M_AXI_LITE_WSTRB   = strb_q;
    assign M_AXI_LITE_WVALID  = wvalid_q;
    assign M_AXI_LITE_BREADY  = bready_q;
    assign M_AXI_LITE_ARADDR  = addr_q;
    assign M_AXI_LITE_ARPROT  = PROT_DEFAULT;
    assign M_AXI_LITE_ARVALID = arvalid_q;
    assign M_AXI_LITE_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master; the slave and response sink are
// driven step by step with hand-computed expectations.
module tb_axi_lite_cmd_master;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_cmp = 0;
    int n_err = 0;

    axi_lite_cmd_master #(
        .C_M_AXI_LITE_DATA_WIDTH(32),
        .C_M_AXI_LITE_ADDR_WIDTH(6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .M_AXI_LITE_ACLK(clk),       .M_AXI_LITE_ARESETN(rst_n),
        .CMD_VALID(cmd_valid),       .CMD_READY(cmd_ready),
        .CMD_WRITE(cmd_write),       .CMD_ADDR(cmd_addr),
        .CMD_DATA(cmd_data),         .CMD_STRB(cmd_strb),
        .RSP_VALID(rsp_valid),       .RSP_READY(rsp_ready),
        .RSP_DATA(rsp_data),         .RSP_RESP(rsp_resp),
        .RSP_TIMEOUT(rsp_timeout),
        .M_AXI_LITE_AWADDR(awaddr),  .M_AXI_LITE_AWPROT(awprot),
        .M_AXI_LITE_AWVALID(awvalid), .M_AXI_LITE_AWREADY(awready),
        .M_AXI_LITE_WDATA(wdata),    .M_AXI_LITE_WSTRB(wstrb),
        .M_AXI_LITE_WVALID(wvalid),  .M_AXI_LITE_WREADY(wready),
        .M_AXI_LITE_BRESP(bresp),    .M_AXI_LITE_BVALID(bvalid),
        .M_AXI_LITE_BREADY(bready),
        .M_AXI_LITE_ARADDR(araddr),  .M_AXI_LITE_ARPROT(arprot),
        .M_AXI_LITE_ARVALID(arvalid), .M_AXI_LITE_ARREADY(arready),
        .M_AXI_LITE_RDATA(rdata),    .M_AXI_LITE_RRESP(rresp),
        .M_AXI_LITE_RVALID(rvalid),  .M_AXI_LITE_RREADY(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL global_timeout: observed hang expected $finish");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_data = '0; cmd_strb = '0; rsp_ready = 1'b1;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;

        // Reset state
        #12;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_valids", {27'b0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
        chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_data[27:0]}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // 1: zero-wait write
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h24;
        cmd_data = 32'hDEADBEEF; cmd_strb = 4'hF; awready = 1'b1; wready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t1_aw_w_rise", {30'b0, awvalid, wvalid}, 32'd3);
        chk("t1_awaddr", {26'b0, awaddr}, 32'h24);
        chk("t1_wdata", wdata, 32'hDEADBEEF);
        chk("t1_wstrb", {28'b0, wstrb}, 32'hF);
        chk("t1_awprot", {29'b0, awprot}, 32'd0);
        chk("t1_busy_no_ready", {31'b0, cmd_ready}, 32'd0);
        tick();
        bvalid = 1'b1; bresp = 2'b00;
        chk("t1_bready", {29'b0, awvalid, wvalid, bready}, 32'd1);
        chk("t1_no_rsp_yet", {31'b0, rsp_valid}, 32'd0);
        tick();
        bvalid = 1'b0;
        chk("t1_rsp_valid_lat3", {31'b0, rsp_valid}, 32'd1);
        chk("t1_rsp_resp_to", {29'b0, rsp_resp, rsp_timeout}, 32'd0);
        chk("t1_rsp_data", rsp_data, 32'd0);
        tick();
        chk("t1_back_idle", {30'b0, rsp_valid, cmd_ready}, 32'd1);

        // 2: AWREADY delayed, WREADY immediate
        awready = 1'b0; wready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h08;
        cmd_data = 32'h0000A5A5; cmd_strb = 4'h3;
        tick();
        cmd_valid = 1'b0;
        chk("t2_aw_w_rise", {30'b0, awvalid, wvalid}, 32'd3);
        tick();
        chk("t2_w_dropped", {30'b0, awvalid, wvalid}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_aw_held", {29'b0, awvalid, wvalid, bready}, 32'd4);
        end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("t2_aw_done_bready", {30'b0, awvalid, bready}, 32'd1);
        bvalid = 1'b1; bresp = 2'b01;
        tick();
        bvalid = 1'b0;
        chk("t2_one_b", {31'b0, bready}, 32'd0);
        chk("t2_rsp", {29'b0, rsp_valid, rsp_resp}, 32'h5);
        tick();
        chk("t2_back_idle", {30'b0, rsp_valid, cmd_ready}, 32'd1);

        // 3: read with RVALID 3 cycles after AR
        arready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h20;
        tick();
        cmd_valid = 1'b0;
        chk("t3_arvalid", {31'b0, arvalid}, 32'd1);
        chk("t3_araddr", {26'b0, araddr}, 32'h20);
        chk("t3_no_aw", {30'b0, awvalid, wvalid}, 32'd0);
        tick();
        chk("t3_ar_drop_rready", {30'b0, arvalid, rready}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t3_wait_r", {30'b0, rready, rsp_valid}, 32'd2);
        end
        rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        chk("t3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t3_rsp_data", rsp_data, 32'h12345678);
        chk("t3_rsp_resp", {30'b0, rsp_resp}, 32'd0);
        tick();
        chk("t3_back_idle", {30'b0, rsp_valid, cmd_ready}, 32'd1);

        // 4: SLVERR read, response sink stalls 4 cycles
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h04;
        tick();
        cmd_valid = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'hCAFE0001; rresp = 2'b10;
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        chk("t4_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t4_rsp_data", rsp_data, 32'hCAFE0001);
        chk("t4_rsp_resp", {30'b0, rsp_resp}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("t4_hold_data", rsp_data, 32'hCAFE0001);
            chk("t4_hold_resp", {30'b0, rsp_resp}, 32'd2);
        end
        rsp_ready = 1'b1;
        tick();
        chk("t4_back_idle", {30'b0, rsp_valid, cmd_ready}, 32'd1);

        // 5: write whose B never arrives within 16 busy cycles
        awready = 1'b1; wready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h10;
        cmd_data = 32'h11112222; cmd_strb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("t5_pre_timeout", {30'b0, rsp_valid, bready}, 32'd1);
        tick();
        chk("t5_timeout_rsp", {29'b0, rsp_valid, rsp_timeout, bready}, 32'd6);
        chk("t5_timeout_resp", {30'b0, rsp_resp}, 32'd3);
        chk("t5_timeout_data", rsp_data, 32'd0);
        tick();
        chk("t5_flush_bready", {29'b0, bready, cmd_ready, rsp_valid}, 32'd4);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t5_flush_hold", {29'b0, bready, cmd_ready, rsp_valid}, 32'd4);
        end
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("t5_flush_exit", {29'b0, bready, cmd_ready, rsp_valid}, 32'd2);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t5_no_second_rsp", {30'b0, rsp_valid, cmd_ready}, 32'd1);
        end

        // 6: reset asserted during RD_DATA
        arready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h0C;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("t6_in_rd_data", {31'b0, rready}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {26'b0, awvalid, wvalid, arvalid, bready, rready, cmd_ready}, 32'd0);
        chk("t6_async_rsp", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_idle_after_rst", {30'b0, cmd_ready, rready}, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
